// File: rtl/cache_req_arbiter_if.sv
// Request/response bundle between the two CPUs, the arbiter and the shared cache.
// The arbiter connects through the slave modport; the CPU/cache side uses master.
interface cache_req_arbiter_if #(
  parameter int REQ_W = 22
);
  logic [REQ_W-1:0] p0_req;
  logic             p0_req_valid;
  logic             p0_req_ready;
  logic [REQ_W-1:0] p1_req;
  logic             p1_req_valid;
  logic             p1_req_ready;
  logic [REQ_W-1:0] cache_request;
  logic             cache_req_valid;
  logic             cache_busy;
  logic [REQ_W-1:0] cache_data;
  logic             cache_resp_valid;
  logic [REQ_W-1:0] p0_resp;
  logic             p0_resp_valid;
  logic [REQ_W-1:0] p1_resp;
  logic             p1_resp_valid;
  logic             pid_err;

  modport slave (
    input  p0_req, p0_req_valid, p1_req, p1_req_valid,
           cache_busy, cache_data, cache_resp_valid,
    output p0_req_ready, p1_req_ready, cache_request, cache_req_valid,
           p0_resp, p0_resp_valid, p1_resp, p1_resp_valid, pid_err
  );

  modport master (
    output p0_req, p0_req_valid, p1_req, p1_req_valid,
           cache_busy, cache_data, cache_resp_valid,
    input  p0_req_ready, p1_req_ready, cache_request, cache_req_valid,
           p0_resp, p0_resp_valid, p1_resp, p1_resp_valid, pid_err
  );
endinterface

// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter: buffers CPU0/CPU1 requests in per-port FIFOs, issues one
// request at a time to the shared cache (round-robin, honouring cache_busy) and
// routes each response back to the CPU named by its pid bit.
// Optional macro ARB_STATS_EN adds saturating grant/conflict counters.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no request outstanding; may issue when cache not busy
// ST_WAIT | request issued, waiting for cache_resp_valid
module cache_req_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int REQ_W      = 22
) (
  input  logic               clk,
  input  logic               reset,
  cache_req_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]        p0_grant_cnt,
  output logic [15:0]        p1_grant_cnt,
  output logic [15:0]        conflict_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t state, next_state;

  logic [REQ_W-1:0] mem [2][FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr [2];
  logic [PW-1:0]    rd_ptr [2];
  logic [REQ_W-1:0] in_word [2];
  logic [1:0]       in_valid;
  logic [1:0]       full, empty, push, pop;
  logic             prio;
  logic             sel;
  logic             grant;
  logic             err_set;

  logic [REQ_W-1:0] req_q, p0_resp_q, p1_resp_q;
  logic             req_valid_q, p0_resp_valid_q, p1_resp_valid_q, pid_err_q;

  assign in_word[0]  = bus.p0_req;
  assign in_word[1]  = bus.p1_req;
  assign in_valid[0] = bus.p0_req_valid;
  assign in_valid[1] = bus.p1_req_valid;

  // FIFO status, push qualification and pid mismatch detection
  always_comb begin
    full    = '0;
    empty   = '0;
    push    = '0;
    for (int i = 0; i < 2; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]) && (wr_ptr[i][AW] != rd_ptr[i][AW]);
      push[i]  = in_valid[i] && !full[i];
    end
    err_set = (push[0] && in_word[0][REQ_W-1]) || (push[1] && !in_word[1][REQ_W-1]);
  end

  assign bus.p0_req_ready = !full[0];
  assign bus.p1_req_ready = !full[1];

  // FIFO storage; pid bit is overwritten with the port index on the way in
  always_ff @(posedge clk) begin
    if (push[0]) mem[0][wr_ptr[0][AW-1:0]] <= {1'b0, in_word[0][REQ_W-2:0]};
    if (push[1]) mem[1][wr_ptr[1][AW-1:0]] <= {1'b1, in_word[1][REQ_W-2:0]};
  end

  // FIFO pointers, wrapping modulo 2*FIFO_DEPTH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
      end
    end
  end

  // Arbitration and next-state: priority only matters when both ports wait
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    sel        = 1'b0;
    pop        = '0;
    if (!empty[0] && !empty[1]) sel = prio;
    else                        sel = empty[0];
    case (state)
      ST_IDLE: begin
        if (!bus.cache_busy && (!empty[0] || !empty[1])) begin
          grant      = 1'b1;
          pop        = sel ? 2'b10 : 2'b01;
          next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.cache_resp_valid) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Issue register and round-robin priority; the request word holds in WAIT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q       <= '0;
      req_valid_q <= 1'b0;
      prio        <= 1'b0;
    end else begin
      req_valid_q <= grant;
      if (grant) begin
        req_q <= mem[sel][rd_ptr[sel][AW-1:0]];
        prio  <= ~sel;
      end
    end
  end

  // Response routing by pid bit, independent of FSM state; sticky pid error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p0_resp_q       <= '0;
      p1_resp_q       <= '0;
      p0_resp_valid_q <= 1'b0;
      p1_resp_valid_q <= 1'b0;
      pid_err_q       <= 1'b0;
    end else begin
      p0_resp_valid_q <= bus.cache_resp_valid && !bus.cache_data[REQ_W-1];
      p1_resp_valid_q <= bus.cache_resp_valid && bus.cache_data[REQ_W-1];
      if (bus.cache_resp_valid && !bus.cache_data[REQ_W-1]) p0_resp_q <= bus.cache_data;
      if (bus.cache_resp_valid && bus.cache_data[REQ_W-1])  p1_resp_q <= bus.cache_data;
      if (err_set) pid_err_q <= 1'b1;
    end
  end

  assign bus.cache_request   = req_q;
  assign bus.cache_req_valid = req_valid_q;
  assign bus.p0_resp         = p0_resp_q;
  assign bus.p0_resp_valid   = p0_resp_valid_q;
  assign bus.p1_resp         = p1_resp_q;
  assign bus.p1_resp_valid   = p1_resp_valid_q;
  assign bus.pid_err         = pid_err_q;

`ifdef ARB_STATS_EN
  // Saturating grant and contention counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p0_grant_cnt <= '0;
      p1_grant_cnt <= '0;
      conflict_cnt <= '0;
    end else begin
      if (grant && !sel && p0_grant_cnt != 16'hFFFF) p0_grant_cnt <= p0_grant_cnt + 16'd1;
      if (grant && sel && p1_grant_cnt != 16'hFFFF)  p1_grant_cnt <= p1_grant_cnt + 16'd1;
      if (state == ST_IDLE && !empty[0] && !empty[1] && !bus.cache_busy &&
          conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule
